mem_write_buffer: RTL and testbench

//  Posted-write FIFO between the MEM stage and MainMemory. Accepts MEM-stage stores in one

---
 rtl/mem_write_buffer.sv | 140 ++++++++++++++
 tb/tb_mem_write_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Posted-write FIFO between MEM stage and main memory with store-to-load bypass and coalescing.
// Zero-latency load hit/store accept; STALL when a store meets a full buffer or a load miss waits on memory.
module mem_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int COALESCE = 1
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     cpu_wr_en,
  input  logic                     cpu_rd_en,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     rd_hit,
  output logic                     STALL,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

  logic [WW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WW-1:0]    cpu_waddr;
  logic [1:0]       unused_addr_lsb;
  logic             wr_req, rd_req;
  logic             match_vld;
  logic [PW-1:0]    match_idx;
  logic             full, load_hit, load_miss, drain, pop;
  logic             coal, app_req, app;

  assign cpu_waddr       = cpu_addr[AW-1:2];
  assign unused_addr_lsb = cpu_addr[1:0];

  // Walk entries oldest to youngest so the last match found is the youngest.
  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head_q + i[PW-1:0];
      if (valid_q[idx] && (addr_q[idx] == cpu_waddr)) begin
        match_vld = 1'b1;
        match_idx = idx;
      end
    end
  end

  always_comb begin
    wr_req    = cpu_wr_en;
    rd_req    = cpu_rd_en & ~cpu_wr_en;
    full      = (count_q == CW'(DEPTH));
    load_hit  = rd_req & match_vld;
    load_miss = rd_req & ~match_vld;
    drain     = (count_q != '0) & ~load_miss;
    pop       = drain & mem_ready;
    // A youngest match sitting in the head that leaves this edge cannot absorb the store.
    coal      = (COALESCE != 0) && wr_req && match_vld && !(pop && (match_idx == head_q));
    app_req   = wr_req & ~coal;
    app       = app_req & ~full;
  end

  always_comb begin
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = app ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(app) - CW'(pop);
  end

  always_comb begin
    cpu_rdata = '0;
    rd_hit    = 1'b0;
    STALL     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!RESET) begin
      STALL = (app_req & full) | (load_miss & ~mem_ready);
      if (load_hit) begin
        rd_hit    = 1'b1;
        cpu_rdata = data_q[match_idx];
      end else if (load_miss) begin
        mem_req   = 1'b1;
        mem_addr  = cpu_addr;
        cpu_rdata = mem_rdata;
      end
      if (drain) begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[head_q], 2'b00};
        mem_wdata = data_q[head_q];
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop) valid_q[head_q] <= 1'b0;
      if (app) valid_q[tail_q] <= 1'b1;
    end
  end

  // Payload needs no reset; valid_q gates every use of it.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      if (app) begin
        addr_q[tail_q] <= cpu_waddr;
        data_q[tail_q] <= cpu_wdata;
      end
      if (coal) data_q[match_idx] <= cpu_wdata;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: reset, full stall, coalescing, load bypass/miss, pop+append.
module tb_mem_write_buffer;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        cpu_wr_en, cpu_rd_en;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        rd_hit, STALL, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  mem_write_buffer #(.DEPTH(4), .AW(32), .DW(32), .COALESCE(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rd_hit(rd_hit), .STALL(STALL),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .empty(empty), .count(count)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory-side write log: a write lands exactly on an accepting edge.
  always @(posedge CLOCK) begin
    if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
    cpu_addr  = '0;   cpu_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mem_ready = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_wr_en = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drain_out();
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; mem_ready = 1'b1;
    for (int n = 0; n < 20 && empty !== 1'b1; n++) step();
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_timeout empty=%b required=1", empty); end
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_rd_en = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b1;
    RESET = 1'b1;
    step();
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d required=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b required=1", empty); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b required=0", mem_req); end
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b required=0", STALL); end
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL rst_rd_hit got=%b required=0", rd_hit); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h required=0", cpu_rdata); end
    RESET = 1'b0;
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    store(32'h100, 32'h1); step();
    store(32'h104, 32'h2); step();
    store(32'h108, 32'h3); step();
    idle_inputs();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_count_pre got=%0d required=3", count); end
    mem_ready = 1'b1;
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_draining got=%b required=1", mem_req); end
    RESET = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_req_in_rst got=%b required=0", mem_req); end
    step();
    RESET = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d required=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b required=1", empty); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_mem_req got=%b required=0", mem_req); end
    step(); step(); step();
    total++; if (wq_addr.size() != 0) begin bad++; $display("FAIL mid_writes got=%0d required=0", wq_addr.size()); end
  endtask

  task automatic test_full_stall();
    logic [31:0] ea [5];
    logic [31:0] ed [5];
    ea = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    ed = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      store(ea[k], ed[k]);
      #1;
      total++; if (STALL !== 1'b0) begin bad++; $display("FAIL fill_stall%0d got=%b required=0", k, STALL); end
      step();
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d required=4", count); end
    store(ea[4], ed[4]);
    #1;
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL full_stall got=%b required=1", STALL); end
    step();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d required=4", count); end
    mem_ready = 1'b1;
    #1;
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL full_pop_stall got=%b required=1", STALL); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL full_head_addr got=%h required=10", mem_addr); end
    step();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL after_pop_count got=%0d required=3", count); end
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL retry_stall got=%b required=0", STALL); end
    step();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL app_pop_count got=%0d required=3", count); end
    drain_out();
    total++; if (wq_addr.size() != 5) begin bad++; $display("FAIL full_nwrites got=%0d required=5", wq_addr.size()); end
    for (int k = 0; k < 5 && k < wq_addr.size(); k++) begin
      total++;
      if (wq_addr[k] !== ea[k] || wq_data[k] !== ed[k]) begin
        bad++; $display("FAIL order%0d got=%h/%h required=%h/%h", k, wq_addr[k], wq_data[k], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_coalesce_hit();
    do_reset();
    store(32'h40, 32'hAA); step();
    store(32'h40, 32'hBB); step();
    idle_inputs();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL coal_count got=%0d required=1", count); end
    cpu_rd_en = 1'b1; cpu_addr = 32'h40;
    #1;
    total++; if (rd_hit !== 1'b1) begin bad++; $display("FAIL hit_flag got=%b required=1", rd_hit); end
    total++; if (cpu_rdata !== 32'hBB) begin bad++; $display("FAIL hit_data got=%h required=bb", cpu_rdata); end
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL hit_stall got=%b required=0", STALL); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL hit_drain_we got=%b required=1", mem_we); end
    step();
    drain_out();
    total++; if (wq_addr.size() != 1) begin bad++; $display("FAIL coal_nwrites got=%0d required=1", wq_addr.size()); end
    if (wq_addr.size() > 0) begin
      total++;
      if (wq_addr[0] !== 32'h40 || wq_data[0] !== 32'hBB) begin
        bad++; $display("FAIL coal_write got=%h/%h required=40/bb", wq_addr[0], wq_data[0]);
      end
    end
  endtask

  task automatic test_load_miss();
    do_reset();
    store(32'h10, 32'h99); step();
    idle_inputs();
    cpu_rd_en = 1'b1; cpu_addr = 32'h80; mem_rdata = 32'h5A;
    #1;
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL miss_wait_stall got=%b required=1", STALL); end
    mem_ready = 1'b1;
    #1;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL miss_req got=%b/%b required=1/0", mem_req, mem_we); end
    total++; if (mem_addr !== 32'h80) begin bad++; $display("FAIL miss_addr got=%h required=80", mem_addr); end
    total++; if (cpu_rdata !== 32'h5A) begin bad++; $display("FAIL miss_data got=%h required=5a", cpu_rdata); end
    total++; if (STALL !== 1'b0 || rd_hit !== 1'b0) begin bad++; $display("FAIL miss_flags got=%b/%b required=0/0", STALL, rd_hit); end
    step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL miss_count got=%0d required=1", count); end
    total++; if (wq_addr.size() != 0) begin bad++; $display("FAIL miss_nodrain got=%0d required=0", wq_addr.size()); end
    cpu_rd_en = 1'b0;
    #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL resume got=%b/%h required=1/10", mem_we, mem_addr); end
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL resume_count got=%0d required=0", count); end
  endtask

  task automatic test_pop_append();
    do_reset();
    store(32'h30, 32'h66); step();
    store(32'h30, 32'h77);
    mem_ready = 1'b1;
    #1;
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL popapp_stall got=%b required=0", STALL); end
    step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL popapp_count got=%0d required=1", count); end
    drain_out();
    total++; if (wq_addr.size() != 2) begin bad++; $display("FAIL popapp_nwrites got=%0d required=2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      total++;
      if (wq_data[0] !== 32'h66 || wq_data[1] !== 32'h77 || wq_addr[1] !== 32'h30) begin
        bad++; $display("FAIL popapp_order got=%h,%h required=66,77", wq_data[0], wq_data[1]);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    mem_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_reset_mid_drain();
    test_full_stall();
    test_coalesce_hit();
    test_load_miss();
    test_pop_append();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
